fake_sram_timed: RTL

- Parametrised behavioural SRAM model for the testbench peripheral set, replacing the fixed 32-bit, zero-latency fake SRAM.
- Configurable data width, depth and read latency, so the CPU memory controller can be exercised against slow SRAM.
- Byte-enabled synchronous writes, a read state machine with wait states, and access counters for bench scoreboarding.
- Sits on the board-level SRAM pins in the top testbench, one instance per SRAM bank.

---
 rtl/fake_sram_timed_if.sv | 27 ++
 rtl/fake_sram_timed.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fake_sram_timed_if.sv
// Control/status bundle for one fake_sram_timed bank; the bidirectional data bus is a separate port.
// The master drives the SRAM control pins and reads back the counters and status.
interface fake_sram_timed_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 20,
  parameter int CNT_WIDTH  = 32
);
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [DATA_WIDTH/8-1:0] ram_be_n;
  logic                    ram_ce_n;
  logic                    ram_oe_n;
  logic                    ram_we_n;
  logic [CNT_WIDTH-1:0]    rd_count;
  logic [CNT_WIDTH-1:0]    wr_count;
  logic                    rd_valid;
  logic                    proto_err;

  modport master (
    output ram_addr, ram_be_n, ram_ce_n, ram_oe_n, ram_we_n,
    input  rd_count, wr_count, rd_valid, proto_err
  );

  modport slave (
    input  ram_addr, ram_be_n, ram_ce_n, ram_oe_n, ram_we_n,
    output rd_count, wr_count, rd_valid, proto_err
  );
endinterface

// File: rtl/fake_sram_timed.sv
// Behavioural SRAM bank with byte-enabled writes, configurable read wait states and access counters.
// Optional protocol checking is compiled in with the FAKE_SRAM_CHECK_EN macro.
module fake_sram_timed #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 20,
  parameter int DEPTH        = 1048576,
  parameter int READ_LATENCY = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  fake_sram_timed_if.slave      bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;

  logic                  w_rd;
  logic                  w_wr;
  logic                  w_bad;
  logic                  w_addr_ok;
  logic                  w_drive;
  logic [ADDR_WIDTH-1:0] w_raddr;
  logic                  w_raddr_ok;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [CNT_WIDTH-1:0]  r_rd_count;
  logic [CNT_WIDTH-1:0]  r_wr_count;

  // Contents survive reset; they only start out zeroed.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};

  assign w_rd      = ~bus.ram_ce_n & ~bus.ram_oe_n &  bus.ram_we_n;
  assign w_wr      = ~bus.ram_ce_n &  bus.ram_oe_n & ~bus.ram_we_n;
  assign w_bad     = ~bus.ram_ce_n & ~bus.ram_oe_n & ~bus.ram_we_n;
  assign w_addr_ok = {1'b0, bus.ram_addr} < DEPTH_A;

  always_ff @(posedge clk) begin
    if (w_wr && w_addr_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (!bus.ram_be_n[b]) begin
          r_mem[bus.ram_addr[IW-1:0]][8*b +: 8] <= ram_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_count <= '0;
    end else if (w_wr) begin
      r_wr_count <= r_wr_count + 1'b1;
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_comb
      logic                  r_prev_rd;
      logic [ADDR_WIDTH-1:0] r_prev_addr;

      // A read counts once per distinct address held under RD.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_prev_rd   <= 1'b0;
          r_prev_addr <= '0;
          r_rd_count  <= '0;
        end else begin
          r_prev_rd   <= w_rd;
          r_prev_addr <= bus.ram_addr;
          if (w_rd && (!r_prev_rd || bus.ram_addr != r_prev_addr)) begin
            r_rd_count <= r_rd_count + 1'b1;
          end
        end
      end

      assign w_drive = w_rd;
      assign w_raddr = bus.ram_addr;
    end else begin : g_fsm
      localparam logic [31:0] RL = 32'(READ_LATENCY);
      state_t                r_state;
      logic [31:0]           r_cnt;
      logic [ADDR_WIDTH-1:0] r_addr;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state    <= S_IDLE;
          r_cnt      <= '0;
          r_addr     <= '0;
          r_rd_count <= '0;
        end else if (!w_rd) begin
          r_state <= S_IDLE;
        end else begin
          case (r_state)
            S_IDLE: begin
              r_addr <= bus.ram_addr;
              r_cnt  <= 32'd1;
              if (RL == 32'd1) begin
                r_state    <= S_DATA;
                r_rd_count <= r_rd_count + 1'b1;
              end else begin
                r_state <= S_WAIT;
              end
            end
            S_WAIT: begin
              if (bus.ram_addr != r_addr) begin
                r_addr <= bus.ram_addr;
                r_cnt  <= 32'd1;
              end else begin
                r_cnt <= r_cnt + 32'd1;
                if (r_cnt + 32'd1 >= RL) begin
                  r_state    <= S_DATA;
                  r_rd_count <= r_rd_count + 1'b1;
                end
              end
            end
            S_DATA: begin
              // With one wait state a new address is already due at the next edge.
              if (bus.ram_addr != r_addr) begin
                r_addr <= bus.ram_addr;
                r_cnt  <= 32'd1;
                if (RL == 32'd1) begin
                  r_rd_count <= r_rd_count + 1'b1;
                end else begin
                  r_state <= S_WAIT;
                end
              end
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end

      assign w_drive = w_rd && (r_state == S_DATA);
      assign w_raddr = r_addr;
    end
  endgenerate

  assign w_raddr_ok = {1'b0, w_raddr} < DEPTH_A;
  assign w_rdata    = w_raddr_ok ? r_mem[w_raddr[IW-1:0]] : '1;
  assign ram_data   = w_drive ? w_rdata : 'z;

  assign bus.rd_valid = w_drive;
  assign bus.rd_count = r_rd_count;
  assign bus.wr_count = r_wr_count;

`ifdef FAKE_SRAM_CHECK_EN
  logic                  r_proto_err;
  logic                  r_prev_wr;
  logic [ADDR_WIDTH-1:0] r_prev_wr_addr;
  logic [NB-1:0]         r_prev_be_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_proto_err    <= 1'b0;
      r_prev_wr      <= 1'b0;
      r_prev_wr_addr <= '0;
      r_prev_be_n    <= '1;
    end else begin
      r_prev_wr <= w_wr;
      if (w_wr) begin
        r_prev_wr_addr <= bus.ram_addr;
        r_prev_be_n    <= bus.ram_be_n;
      end
      if (w_bad) begin
        r_proto_err <= 1'b1;
        $display("%0t fake_sram_timed addr %h: OE and WE both asserted", $time, bus.ram_addr);
      end
      if ((w_wr || w_rd) && !w_addr_ok) begin
        r_proto_err <= 1'b1;
        $display("%0t fake_sram_timed addr %h: access beyond DEPTH", $time, bus.ram_addr);
      end
      if (w_wr && r_prev_wr && bus.ram_addr == r_prev_wr_addr && bus.ram_be_n != r_prev_be_n) begin
        r_proto_err <= 1'b1;
        $display("%0t fake_sram_timed addr %h: byte enables changed within a write burst", $time, bus.ram_addr);
      end
    end
  end

  assign bus.proto_err = r_proto_err;
`else
  assign bus.proto_err = 1'b0;
`endif

endmodule
